// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if
//   Serial-audio bundle between the codec side and the i2s_receiver.
//   Signals:
//     lrck     - frame clock from codec; each edge begins a channel slot
//     bck      - bit clock to codec (driven by the receiver)
//     data_in  - serial data, MSB first
//     data_out - last complete parallel word
//     count    - bits captured in the current slot
//     data_rdy - one-cycle strobe when data_out updates
//   Modports:
//     master - the receiver: it sources bck and the parallel outputs
//     slave  - the codec/environment: it sources lrck and data_in
interface i2s_receiver_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 5
);
    logic                  lrck;
    logic                  bck;
    logic                  data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CNT_WIDTH-1:0]  count;
    logic                  data_rdy;

    modport master (
        input  lrck, data_in,
        output bck, data_out, count, data_rdy
    );

    modport slave (
        output lrck, data_in,
        input  bck, data_out, count, data_rdy
    );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver
//   Left-justified, MSB-first serial audio receiver. Every lrck transition
//   starts a slot; the bit sampled on that same mck edge is the MSB. After
//   DATA_WIDTH bits the word is published on data_out with a one-cycle
//   data_rdy strobe; further bits in the slot are ignored. A slot cut short
//   by an lrck transition is discarded.
//   Ports:
//     mck   - master clock, all state on rising edge
//     rst_n - asynchronous active-low reset
//     bus   - i2s_receiver_if.master (lrck, data_in in; bck, data_out,
//             count, data_rdy out)
module i2s_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 5
) (
    input  logic            mck,
    input  logic            rst_n,
    i2s_receiver_if.master  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic                  lrck_d;
    // The oldest shifted bit can never reach data_out (a word is assembled
    // from sr's low DATA_WIDTH-1 bits plus the incoming bit), so it is not
    // stored.
    logic [DATA_WIDTH-2:0] sr;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_rdy;
    logic                  slot_start;

    assign slot_start = (bus.lrck != lrck_d);

    // Codec bit clock runs 1:1 with mck; the codec launches data on the
    // falling edge so it is stable at our rising-edge sample point.
    assign bus.bck      = mck;
    assign bus.data_out = data_out;
    assign bus.count    = count;
    assign bus.data_rdy = data_rdy;

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is reset along with the control
            // state so a word can never be assembled from stale bits.
            lrck_d   <= 1'b0;
            sr       <= '0;
            count    <= CNT_FULL;   // idle until the first lrck edge
            data_out <= '0;
            data_rdy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge values of count and sr.
            lrck_d   <= bus.lrck;
            data_rdy <= 1'b0;
            if (slot_start) begin
                // New slot wins over a word that would complete this edge.
                sr    <= {sr[DATA_WIDTH-3:0], bus.data_in};
                count <= CNT_WIDTH'(1);
            end else if (count < CNT_FULL) begin
                sr    <= {sr[DATA_WIDTH-3:0], bus.data_in};
                count <= count + 1'b1;
                if (count == CNT_LAST) begin
                    data_out <= {sr, bus.data_in};
                    data_rdy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
//   Self-checking bench for i2s_receiver. A behavioural model keeps the bits
//   of the current slot in a queue and publishes a word when the queue
//   reaches DATA_WIDTH entries; every cycle the DUT outputs are compared
//   with it on the falling edge of mck. Directed scenarios add explicit
//   checks against constant words and strobe counts.
module tb_i2s_receiver;
    localparam int DW = 24;
    localparam int CW = 5;

    logic mck   = 1'b0;
    logic rst_n = 1'b0;

    i2s_receiver_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_if ();

    i2s_receiver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .mck   (mck),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 mck = ~mck;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   rdy_seen = 0;
    logic cur_lvl  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_prev  = 1'b0;
    bit            m_armed = 1'b0;
    bit            m_q[$];
    logic [DW-1:0] exp_out = '0;
    logic          exp_rdy = 1'b0;

    always @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            m_prev  = 1'b0;
            m_armed = 1'b0;
            m_q.delete();
            exp_out = '0;
            exp_rdy = 1'b0;
        end else begin
            exp_rdy = 1'b0;
            if (bus_if.lrck !== m_prev) begin
                m_q.delete();
                m_q.push_back(bus_if.data_in);
                m_armed = 1'b1;
            end else if (m_armed && m_q.size() < DW) begin
                m_q.push_back(bus_if.data_in);
                if (m_q.size() == DW) begin
                    exp_out = '0;
                    foreach (m_q[i]) exp_out[DW-1-i] = m_q[i];
                    exp_rdy = 1'b1;
                end
            end
            m_prev = bus_if.lrck;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge mck) begin
        check("bck_low", 32'(bus_if.bck), 32'd0);
        check("count", 32'(bus_if.count), m_armed ? m_q.size() : DW);
        check("data_out", 32'(bus_if.data_out), 32'(exp_out));
        check("data_rdy", 32'(bus_if.data_rdy), 32'(exp_rdy));
        if (bus_if.data_rdy === 1'b1) rdy_seen++;
    end

    always @(posedge mck) begin
        #1;
        check("bck_high", 32'(bus_if.bck), 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic lv, input logic b);
        @(negedge mck);
        #1;
        bus_if.lrck    = lv;
        bus_if.data_in = b;
    endtask

    task automatic settle();
        @(negedge mck);
        #1;
    endtask

    task automatic new_slot();
        cur_lvl = ~cur_lvl;
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int first, input int last);
        for (int i = first; i <= last; i++)
            drive(cur_lvl, (i < DW) ? w[DW-1-i] : 1'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int            base;
        logic [DW-1:0] w;
        int            len;

        bus_if.lrck    = 1'b0;
        bus_if.data_in = 1'b0;

        // Reset held with data toggling, then released with lrck constant.
        repeat (4) drive(1'b0, 1'($urandom));
        settle();
        check("rst_count", 32'(bus_if.count), 32'd24);
        check("rst_data_out", 32'(bus_if.data_out), 32'h000000);
        check("rst_data_rdy", 32'(bus_if.data_rdy), 32'd0);
        rst_n = 1'b1;
        base = rdy_seen;
        repeat (5) drive(1'b0, 1'($urandom));
        settle();
        check("idle_count", 32'(bus_if.count), 32'd24);
        check("idle_rdy", 32'(rdy_seen - base), 32'd0);

        // Nominal frames: 30-cycle half-period, 0x888888 each slot.
        for (int s = 0; s < 4; s++) begin
            base = rdy_seen;
            new_slot();
            send_bits(24'h888888, 0, 29);
            settle();
            check("nom_word", 32'(bus_if.data_out), 32'h888888);
            check("nom_count", 32'(bus_if.count), 32'd24);
            check("nom_rdy", 32'(rdy_seen - base), 32'd1);
        end

        // Alternating words per lrck level.
        for (int s = 0; s < 4; s++) begin
            base = rdy_seen;
            new_slot();
            w = cur_lvl ? 24'h123456 : 24'hABCDEF;
            send_bits(w, 0, 29);
            settle();
            check("alt_word", 32'(bus_if.data_out), cur_lvl ? 32'h123456 : 32'hABCDEF);
            check("alt_rdy", 32'(rdy_seen - base), 32'd1);
        end

        // Short slot: 10 bits then a new transition.
        w = bus_if.data_out;
        base = rdy_seen;
        new_slot();
        send_bits(24'h5A5A5A, 0, 9);
        settle();
        new_slot();
        send_bits(24'hC3C3C3, 0, 0);
        settle();
        check("short_count", 32'(bus_if.count), 32'd1);
        check("short_rdy", 32'(rdy_seen - base), 32'd0);
        check("short_hold", 32'(bus_if.data_out), 32'(w));
        send_bits(24'hC3C3C3, 1, 28);

        // Collision: transition on the edge that would take bit 24.
        settle();
        w = bus_if.data_out;
        base = rdy_seen;
        new_slot();
        send_bits(24'h777777, 0, 22);
        new_slot();
        send_bits(24'h111111, 0, 0);
        settle();
        check("coll_count", 32'(bus_if.count), 32'd1);
        check("coll_rdy", 32'(rdy_seen - base), 32'd0);
        check("coll_hold", 32'(bus_if.data_out), 32'(w));
        send_bits(24'h111111, 1, 28);

        // Mid-slot reset on a low slot, so release does not look like an edge.
        if (cur_lvl == 1'b0) begin
            new_slot();
            send_bits(24'h0F0F0F, 0, 29);
        end
        new_slot();
        send_bits(24'hFEDCBA, 0, 11);
        settle();
        rst_n = 1'b0;
        repeat (2) drive(cur_lvl, 1'($urandom));
        settle();
        check("mid_rst_count", 32'(bus_if.count), 32'd24);
        check("mid_rst_data", 32'(bus_if.data_out), 32'h000000);
        base = rdy_seen;
        rst_n = 1'b1;
        send_bits(24'hFEDCBA, 12, 29);
        settle();
        check("mid_rst_nordy", 32'(rdy_seen - base), 32'd0);
        check("mid_rst_idle", 32'(bus_if.count), 32'd24);
        new_slot();
        send_bits(24'h2468AC, 0, 29);
        settle();
        check("mid_rst_word", 32'(bus_if.data_out), 32'h2468AC);
        check("mid_rst_rdy", 32'(rdy_seen - base), 32'd1);

        // Randomized slots, lengths and occasional resets.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                settle();
                rst_n   = 1'b0;
                cur_lvl = 1'($urandom);
                repeat (2) drive(cur_lvl, 1'($urandom));
                settle();
                rst_n = 1'b1;
                send_bits(24'($urandom), 0, 3);
            end else begin
                new_slot();
                if ($urandom_range(0, 9) < 7) len = $urandom_range(24, 34);
                else                          len = $urandom_range(1, 40);
                send_bits(24'($urandom), 0, len - 1);
            end
        end

        settle();
        settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Serial audio receiver that deserialises a left-justified, MSB-first audio stream into parallel 24-bit words. It sits at the input of the audio pedal datapath, between the external ADC/codec serial interface and the sample-processing logic. The frame clock (lrck) is supplied externally. The block forwards the bit clock to the codec and raises a one-cycle strobe each time a complete word is available.

## Interface
- DATA_WIDTH, 24: bits captured per channel slot. Width of data_out.
- CNT_WIDTH, 5: width of count. Must hold the value DATA_WIDTH.
- mck  input  1  master clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- lrck  input  1  frame (left/right) clock from codec; every transition starts a new channel slot
- bck  output  1  bit clock to codec; combinational copy of mck (1:1 ratio); codec changes data on falling edge
- data_in  input  1  serial data, MSB first, sampled on mck rising edge
- data_out  output  DATA_WIDTH  last complete received word, held until next word completes
- count  output  CNT_WIDTH  number of bits captured in the current slot (0..DATA_WIDTH)
- data_rdy  output  1  one-mck-cycle strobe: data_out has just been updated

## Operation
- Registers: lrck_d (previous lrck), shift register sr[DATA_WIDTH-1:0], count, data_out, data_rdy.
- Slot-start detection: slot_start = (lrck != lrck_d). lrck_d <= lrck every cycle.
- Format: left-justified, no one-bit I2S delay. The bit sampled on the same edge that detects slot_start is the MSB.
- On each rising mck edge, priority order:
  - slot_start: sr <= {sr[DATA_WIDTH-2:0], data_in}; count <= 1.
  - else if count < DATA_WIDTH: shift data_in into sr LSB; count <= count + 1.
  - else (count == DATA_WIDTH): idle. Remaining slot bits are ignored and count holds at DATA_WIDTH.
- Word completion: when a non-slot_start shift takes count from DATA_WIDTH-1 to DATA_WIDTH:
  - data_out <= {sr[DATA_WIDTH-2:0], data_in}
  - data_rdy <= 1
- data_rdy is 0 on every other cycle.
- Both lrck levels are treated identically; no channel tag is output.
- Short slot: if lrck toggles before DATA_WIDTH bits are captured, the partial word is discarded. No data_rdy is raised, and data_out keeps its old value.
- Simultaneous events: slot_start on the edge that would capture the last bit means slot_start wins. The word is discarded and the new slot begins with count = 1.
- Slots longer than DATA_WIDTH bits: extra bits are ignored and count saturates.

## Timing
- Reset (asynchronous, rst_n low):
  - count = DATA_WIDTH (idle, waiting for first lrck transition)
  - data_out = 0, data_rdy = 0, sr = 0, lrck_d = 0
- If lrck is high when reset releases, the first rising edge counts as a slot start.
- Reset mid-slot: the partial word is lost, and capture resumes only at the next lrck transition.
- Latency: with the MSB sampled at edge E0 (lrck transition edge), the LSB is sampled at edge E(DATA_WIDTH-1). data_out and data_rdy update at that same edge, so both are visible for the following cycle.
- Throughput: one word per lrck half-period. The minimum half-period is DATA_WIDTH mck cycles.
- bck has zero latency relative to mck; it is the only combinational output.

## Test plan
- Reset: hold rst_n low with data_in toggling -> count=24, data_out=0x000000, data_rdy=0. Release with lrck constant -> no capture, count stays 24.
- Nominal frames: lrck half-period 30 mck cycles, data_in drives 0x888888 MSB-first starting on the lrck-transition edge.
  - data_rdy is high for exactly one cycle, 24 edges after each transition, with data_out=0x888888.
  - count runs 1..24, then holds at 24 for the remaining 6 cycles.
- Alternating words: send 0xABCDEF on low slot and 0x123456 on high slot -> data_out alternates 0xABCDEF / 0x123456, one data_rdy per slot.
- Short slot: lrck toggles after 10 bits -> no data_rdy, data_out unchanged, count restarts at 1.
- Collision: lrck toggles on the edge where bit 24 would be sampled -> no data_rdy, count=1.
- Mid-slot reset: assert rst_n low after 12 bits, release -> no data_rdy until one full 24-bit slot after the next lrck transition.
